btn_cmd_ctrl: RTL and testbench

Shared button front-end controller for the stopwatch/DHT top level. Samples up to `N_BTN` raw push-buttons on one shared sampling tick, debounces each with hysteresis, and classifies presses as short, long or auto-repeat. A round-robin arbiter then serialises the resulting events into a single valid/ready command stream for the mode/control FSM.

---
 rtl/btn_cmd_ctrl_if.sv | 26 ++
 rtl/btn_cmd_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_btn_cmd_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/btn_cmd_ctrl_if.sv
// btn_cmd_ctrl_if: command stream from the button front end to the mode FSM.
// master drives o_cmd_valid/o_cmd_id/o_cmd_long, slave drives i_cmd_ready.
interface btn_cmd_ctrl_if #(
   parameter int N_BTN = 4
);
   localparam int IW = $clog2(N_BTN);

   logic          o_cmd_valid;
   logic [IW-1:0] o_cmd_id;
   logic          o_cmd_long;
   logic          i_cmd_ready;

   modport master (
      output o_cmd_valid,
      output o_cmd_id,
      output o_cmd_long,
      input  i_cmd_ready
   );

   modport slave (
      input  o_cmd_valid,
      input  o_cmd_id,
      input  o_cmd_long,
      output i_cmd_ready
   );
endinterface

// File: rtl/btn_cmd_ctrl.sv
// btn_cmd_ctrl: shared tick, 2-FF sync, hysteresis debounce and press
// classification (short/long/repeat) for N_BTN buttons, round-robin
// serialised onto one valid/ready command stream.
// Ports: clk, rst (async, active-low), i_btn raw levels, o_btn_level
// debounced levels, o_overrun merge pulse, cmd (master: valid/id/long,
// ready in).
// Option: define BTN_REPEAT_EN for auto-repeat long events while held.
module btn_cmd_ctrl #(
   parameter int N_BTN        = 4,
   parameter int TICK_DIV     = 100000,
   parameter int DB_DEPTH     = 4,
   parameter int LONG_TICKS   = 1000,
   parameter int REPEAT_TICKS = 200
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] i_btn,
   output logic [N_BTN-1:0] o_btn_level,
   output logic             o_overrun,
   btn_cmd_ctrl_if.master   cmd
);
   localparam int IW   = $clog2(N_BTN);
   localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HMAX = (LONG_TICKS > REPEAT_TICKS) ?
                         LONG_TICKS : REPEAT_TICKS;
   localparam int HW   = $clog2(HMAX + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [HW-1:0] LONG_LAST = HW'(LONG_TICKS - 1);
`ifdef BTN_REPEAT_EN
   localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_TICKS - 1);
`endif

   typedef enum logic [1:0] {IDLE, PRESSED, HELD} st_t;

   logic [TW-1:0]       tcnt;
   logic                tick;
   logic                tick_seen;
   logic [N_BTN-1:0]    s1, s2;
   logic [DB_DEPTH-1:0] sh [N_BTN];
   logic [N_BTN-1:0]    all1, all0;
   logic [N_BTN-1:0]    armed;
   st_t                 st_q [N_BTN];
   st_t                 st_n [N_BTN];
   logic [HW-1:0]       cnt_q [N_BTN];
   logic [HW-1:0]       cnt_n [N_BTN];
   logic [N_BTN-1:0]    hit, set_s, set_l;
   logic [N_BTN-1:0]    sp, lp, clr_s, clr_l;
   logic [IW-1:0]       last, g_idx, cand;
   logic                g_vld, g_long, load;
   int                  j;

   assign tick = (tcnt == TICK_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tcnt      <= '0;
         tick_seen <= 1'b0;
      end else begin
         tcnt <= tick ? '0 : tcnt + TW'(1);
         if (tick) tick_seen <= 1'b1;
      end
   end

   always_comb begin
      all1 = '0;
      all0 = '0;
      for (int i = 0; i < N_BTN; i++) begin
         all1[i] = &sh[i];
         all0[i] = ~|sh[i];
      end
   end

   // armed: a button must be seen fully released after reset before a
   // rise counts, so a press held across reset yields no event.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1          <= '0;
         s2          <= '0;
         o_btn_level <= '0;
         armed       <= '0;
         for (int i = 0; i < N_BTN; i++) sh[i] <= '0;
      end else begin
         s1 <= i_btn;
         s2 <= s1;
         for (int i = 0; i < N_BTN; i++) begin
            if (tick) sh[i] <= {sh[i][DB_DEPTH-2:0], s2[i]};
            if (all1[i]) o_btn_level[i] <= 1'b1;
            else if (all0[i]) o_btn_level[i] <= 1'b0;
            if (tick_seen && all0[i]) armed[i] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_BTN; i++) begin
            st_q[i]  <= IDLE;
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            st_q[i]  <= st_n[i];
            cnt_q[i] <= cnt_n[i];
         end
      end
   end

   always_comb begin
      hit = '0;
      for (int i = 0; i < N_BTN; i++) begin
         if (tick && o_btn_level[i]) begin
            if (st_q[i] == PRESSED && cnt_q[i] == LONG_LAST)
               hit[i] = 1'b1;
`ifdef BTN_REPEAT_EN
            if (st_q[i] == HELD && cnt_q[i] == REP_LAST)
               hit[i] = 1'b1;
`endif
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N_BTN; i++) begin
         st_n[i]  = st_q[i];
         cnt_n[i] = cnt_q[i];
         unique case (st_q[i])
            IDLE: begin
               if (o_btn_level[i] && armed[i]) begin
                  st_n[i]  = PRESSED;
                  cnt_n[i] = '0;
               end
            end
            PRESSED: begin
               if (!o_btn_level[i]) st_n[i] = IDLE;
               else if (hit[i]) begin
                  st_n[i]  = HELD;
                  cnt_n[i] = '0;
               end else if (tick) cnt_n[i] = cnt_q[i] + HW'(1);
            end
            HELD: begin
               if (!o_btn_level[i]) st_n[i] = IDLE;
`ifdef BTN_REPEAT_EN
               else if (hit[i]) cnt_n[i] = '0;
               else if (tick) cnt_n[i] = cnt_q[i] + HW'(1);
`endif
            end
            default: st_n[i] = IDLE;
         endcase
      end
   end

   always_comb begin
      set_s = '0;
      set_l = '0;
      for (int i = 0; i < N_BTN; i++) begin
         set_s[i] = (st_q[i] == IDLE) && o_btn_level[i] && armed[i];
         set_l[i] = hit[i];
      end
   end

   // Round-robin search from last+1; short before long per button.
   always_comb begin
      g_vld  = 1'b0;
      g_idx  = '0;
      g_long = 1'b0;
      cand   = '0;
      j      = 0;
      for (int k = 0; k < N_BTN; k++) begin
         j = int'(last) + 1 + k;
         if (j >= N_BTN) j = j - N_BTN;
         cand = IW'(j);
         if (!g_vld && (sp[cand] || lp[cand])) begin
            g_vld  = 1'b1;
            g_idx  = cand;
            g_long = !sp[cand];
         end
      end
   end

   assign load = !cmd.o_cmd_valid || cmd.i_cmd_ready;

   always_comb begin
      clr_s = '0;
      clr_l = '0;
      if (load && g_vld) begin
         if (g_long) clr_l[g_idx] = 1'b1;
         else clr_s[g_idx] = 1'b1;
      end
   end

   // Set beats clear; a set onto a bit that stays pending is a merge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sp              <= '0;
         lp              <= '0;
         o_overrun       <= 1'b0;
         last            <= IW'(N_BTN - 1);
         cmd.o_cmd_valid <= 1'b0;
         cmd.o_cmd_id    <= '0;
         cmd.o_cmd_long  <= 1'b0;
      end else begin
         sp        <= (sp & ~clr_s) | set_s;
         lp        <= (lp & ~clr_l) | set_l;
         o_overrun <= |((sp & ~clr_s & set_s) | (lp & ~clr_l & set_l));
         if (load) begin
            cmd.o_cmd_valid <= g_vld;
            if (g_vld) begin
               cmd.o_cmd_id   <= g_idx;
               cmd.o_cmd_long <= g_long;
               last           <= g_idx;
            end
         end
      end
   end
endmodule

// File: tb/tb_btn_cmd_ctrl.sv
// tb_btn_cmd_ctrl: directed bench for btn_cmd_ctrl with
// TICK_DIV=4, DB_DEPTH=4, LONG_TICKS=8, REPEAT_TICKS=3.
module tb_btn_cmd_ctrl;
   localparam int N_BTN = 4;
`ifdef BTN_REPEAT_EN
   localparam int EXP_LONG = 5;
`else
   localparam int EXP_LONG = 1;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [N_BTN-1:0] btn = '0;
   logic [N_BTN-1:0] level;
   logic             overrun;

   btn_cmd_ctrl_if #(.N_BTN(N_BTN)) cmd_if ();

   btn_cmd_ctrl #(
      .N_BTN(N_BTN),
      .TICK_DIV(4),
      .DB_DEPTH(4),
      .LONG_TICKS(8),
      .REPEAT_TICKS(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .i_btn(btn),
      .o_btn_level(level),
      .o_overrun(overrun),
      .cmd(cmd_if)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int rel     = 0;
   int n_ovr   = 0;
   int bad;
   bit lvl1_hi = 1'b0;
   int q_id[$];
   int q_long[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst) begin
         if (cmd_if.o_cmd_valid && cmd_if.i_cmd_ready) begin
            q_id.push_back(int'(cmd_if.o_cmd_id));
            q_long.push_back(int'(cmd_if.o_cmd_long));
         end
         if (overrun) n_ovr++;
         if (level[1]) lvl1_hi = 1'b1;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int cnt_ev(input int id, input int lng);
      int c = 0;
      for (int i = 0; i < q_id.size(); i++)
         if (q_id[i] == id && q_long[i] == lng) c++;
      return c;
   endfunction

   task automatic clear_log();
      q_id.delete();
      q_long.delete();
      n_ovr   = 0;
      lvl1_hi = 1'b0;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      step(n);
      rst = 1'b1;
      rel = cyc;
      clear_log();
   endtask

   // Park just after a tick edge so the press timing is deterministic.
   task automatic align();
      step(1);
      while (((cyc - rel) % 4) != 0) step(1);
   endtask

   task automatic wait_valid(input string tag);
      int t = 0;
      while (cmd_if.o_cmd_valid !== 1'b1 && t < 200) begin
         step(1);
         t++;
      end
      chk(tag, cmd_if.o_cmd_valid, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cmd_if.i_cmd_ready = 1'b1;
      rst = 1'b0;
      btn = '0;
      step(3);
      chk("rst_level", level, 0);
      chk("rst_valid", cmd_if.o_cmd_valid, 0);
      chk("rst_id", cmd_if.o_cmd_id, 0);
      chk("rst_long", cmd_if.o_cmd_long, 0);
      chk("rst_ovr", overrun, 0);
      rst = 1'b1;
      rel = cyc;

      // Reset in the middle of a held press.
      align();
      btn[0] = 1'b1;
      step(24);
      chk("pre_rst_level", level[0], 1);
      rst = 1'b0;
      #1;
      chk("mid_rst_level", level, 0);
      chk("mid_rst_valid", cmd_if.o_cmd_valid, 0);
      chk("mid_rst_ovr", overrun, 0);
      step(3);
      rst = 1'b1;
      rel = cyc;
      clear_log();
      step(48);
      chk("midrst_no_cmd", q_id.size(), 0);
      btn[0] = 1'b0;
      step(40);
      chk("midrst_no_cmd_rel", q_id.size(), 0);

      // Clean short press with level latency.
      align();
      btn[0] = 1'b1;
      step(16);
      chk("lvl_before_rise", level[0], 0);
      step(1);
      chk("lvl_rise", level[0], 1);
      step(7);
      btn[0] = 1'b0;
      step(40);
      chk("short_total", q_id.size(), 1);
      chk("short_btn0", cnt_ev(0, 0), 1);

      // Bounce on btn1, toggling every tick.
      clear_log();
      align();
      for (int i = 0; i < 12; i++) begin
         btn[1] = ~btn[1];
         step(4);
      end
      btn[1] = 1'b0;
      step(24);
      chk("bnc_level", lvl1_hi, 0);
      chk("bnc_cmd", q_id.size(), 0);
      chk("bnc_ovr", n_ovr, 0);

      // Long press on btn2, level held 22 ticks.
      clear_log();
      align();
      btn[2] = 1'b1;
      step(88);
      btn[2] = 1'b0;
      step(40);
      chk("long_short", cnt_ev(2, 0), 1);
      chk("long_long", cnt_ev(2, 1), EXP_LONG);
      chk("long_total", q_id.size(), 1 + EXP_LONG);

      // Arbitration and stall after a fresh reset.
      do_reset(3);
      cmd_if.i_cmd_ready = 1'b0;
      align();
      btn[1] = 1'b1;
      btn[3] = 1'b1;
      wait_valid("arb_valid");
      btn[1] = 1'b0;
      btn[3] = 1'b0;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (cmd_if.o_cmd_valid !== 1'b1 || cmd_if.o_cmd_id !== 2'd1 ||
             cmd_if.o_cmd_long !== 1'b0) bad++;
         step(1);
      end
      chk("arb_stall_hold", bad, 0);
      cmd_if.i_cmd_ready = 1'b1;
      step(4);
      chk("arb_n", q_id.size(), 2);
      chk("arb_first", q_id[0], 1);
      chk("arb_second", q_id[1], 3);
      align();
      btn[0] = 1'b1;
      btn[2] = 1'b1;
      step(24);
      btn[0] = 1'b0;
      btn[2] = 1'b0;
      step(30);
      chk("arb_n2", q_id.size(), 4);
      chk("arb_third", q_id[2], 0);
      chk("arb_fourth", q_id[3], 2);

      // Overrun: btn0 pressed twice while the output is busy with btn3.
      clear_log();
      cmd_if.i_cmd_ready = 1'b0;
      align();
      btn[3] = 1'b1;
      step(20);
      btn[3] = 1'b0;
      wait_valid("ovr_busy");
      chk("ovr_busy_id", cmd_if.o_cmd_id, 3);
      align();
      btn[0] = 1'b1;
      step(24);
      btn[0] = 1'b0;
      step(40);
      chk("ovr_none_yet", n_ovr, 0);
      align();
      btn[0] = 1'b1;
      step(24);
      btn[0] = 1'b0;
      step(40);
      chk("ovr_pulses", n_ovr, 1);
      cmd_if.i_cmd_ready = 1'b1;
      step(8);
      chk("ovr_total", q_id.size(), 2);
      chk("ovr_btn0", cnt_ev(0, 0), 1);
      chk("ovr_btn3", cnt_ev(3, 0), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
